// File: rtl/median_stream_seq.sv
// Streaming median/min/max over non-overlapping N-sample windows.
// Collects N samples, sorts them over N cycles (odd-even transposition) and offers the result over valid/ready.
module median_stream_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_median,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam int unsigned MID = (N - 1) / 2;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] phase_q;
    logic [WIDTH-1:0] win_q  [N];
    logic [WIDTH-1:0] swap_c [N];
    logic             accept_c;
    logic             sort_last_c;

    assign accept_c    = in_valid && in_ready;
    assign sort_last_c = (phase_q == LAST);

    // State register; handshake flags are registered copies of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == S_LOAD);
            out_valid <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (accept_c && (cnt_q == LAST)) state_d = S_SORT;
            S_SORT:  if (sort_last_c) state_d = S_DONE;
            S_DONE:  if (out_valid && out_ready) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // One compare-exchange bank; phase parity selects even or odd pairs, equal values stay put
    always_comb begin
        swap_c = win_q;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if ((1'(i) == phase_q[0]) && (win_q[i] > win_q[i+1])) begin
                swap_c[i]   = win_q[i+1];
                swap_c[i+1] = win_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) win_q[i] <= '0;
            cnt_q      <= '0;
            phase_q    <= '0;
            out_median <= '0;
            out_min    <= '0;
            out_max    <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept_c) begin
                        win_q[cnt_q] <= in_data;
                        cnt_q        <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                S_SORT: begin
                    win_q   <= swap_c;
                    phase_q <= sort_last_c ? '0 : phase_q + CNT_W'(1);
                    if (sort_last_c) begin
                        out_median <= swap_c[MID];
                        out_min    <= swap_c[0];
                        out_max    <= swap_c[N-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
